// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse event path: register map and packet entry layout.
package ps2_pkg;

  localparam int FIELD_W = 9;

  localparam logic [1:0] STATUS    = 2'b00;
  localparam logic [1:0] POS_X     = 2'b01;
  localparam logic [1:0] POS_Y     = 2'b10;
  localparam logic [1:0] FIFO_STAT = 2'b11;

  typedef struct packed {
    logic [FIELD_W-1:0] status;
    logic [FIELD_W-1:0] x;
    logic [FIELD_W-1:0] y;
  } entry_t;

endpackage

// File: rtl/mouse_fifo_mem.sv
// Packet storage for the mouse event FIFO: one write port, asynchronous read port, no reset.
module mouse_fifo_mem
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  entry_t                     wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output entry_t                     rdata
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mouse_event_fifo.sv
// Mouse packet FIFO with a CPU read port; reading POS_Y pops the head.
// Define MOUSE_FIFO_IRQ_EN to add the registered irq output.
module mouse_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [8:0] pkt_status,
  input  logic [8:0] pkt_x,
  input  logic [8:0] pkt_y,
  input  logic       io_cs,
  input  logic       io_rd,
  input  logic [1:0] addr,
  output logic [8:0] data
`ifdef MOUSE_FIFO_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [6:0]    DEPTH_C = 7'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [6:0]    count;
  logic          overflow;
  logic          empty, full;
  logic          pop, push_ok, ovf_set, stat_rd;
  entry_t        head, wr_entry;

  assign empty    = (count == 7'd0);
  assign full     = (count == DEPTH_C);
  assign pop      = io_cs && io_rd && (addr == POS_Y) && !empty;
  // A full FIFO still accepts a packet when the head leaves on the same edge.
  assign push_ok  = pkt_valid && (!full || pop);
  assign ovf_set  = pkt_valid && full && !pop;
  assign stat_rd  = io_cs && io_rd && (addr == FIFO_STAT);
  assign wr_entry = '{status: pkt_status, x: pkt_x, y: pkt_y};

  mouse_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 7'd0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count <= count + 7'd1;
        2'b01:   count <= count - 7'd1;
        default: count <= count;
      endcase
      // A new overflow beats a same-edge status read clear.
      overflow <= ovf_set | (overflow & ~stat_rd);
    end
  end

  always_comb begin
    data = 9'd0;
    case (addr)
      STATUS:    data = empty ? 9'd0 : head.status;
      POS_X:     data = empty ? 9'd0 : head.x;
      POS_Y:     data = empty ? 9'd0 : head.y;
      FIFO_STAT: data = {overflow, empty, count};
      default:   data = 9'd0;
    endcase
  end

`ifdef MOUSE_FIFO_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq <= 1'b0;
    else      irq <= !empty || overflow;
  end
`endif

endmodule

// File: tb/tb_mouse_event_fifo.sv
// Directed bench for mouse_event_fifo with a queue-based reference model.
module tb_mouse_event_fifo;
  import ps2_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [8:0] pkt_status = '0, pkt_x = '0, pkt_y = '0;
  logic       io_cs = 1'b0, io_rd = 1'b0;
  logic [1:0] addr = 2'b00;
  logic [8:0] data;
`ifdef MOUSE_FIFO_IRQ_EN
  logic       irq;
`endif

  mouse_event_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pkt_valid  (pkt_valid),
    .pkt_status (pkt_status),
    .pkt_x      (pkt_x),
    .pkt_y      (pkt_y),
    .io_cs      (io_cs),
    .io_rd      (io_rd),
    .addr       (addr),
    .data       (data)
`ifdef MOUSE_FIFO_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [26:0] sb[$];
  logic        ovf_m = 1'b0;
  logic        irq_m = 1'b0;

  function automatic logic [26:0] pk(input logic [8:0] s, input logic [8:0] x, input logic [8:0] y);
    return {s, x, y};
  endfunction

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic peek(input logic [1:0] a, output logic [8:0] d);
    io_cs = 1'b0;
    io_rd = 1'b0;
    addr  = a;
    #1;
    d = data;
  endtask

  task automatic check_all(input string tag);
    logic [26:0] h;
    logic [8:0]  d;
    h = (sb.size() != 0) ? sb[0] : 27'd0;
    peek(2'b00, d); check({tag, ".status"}, d, h[26:18]);
    peek(2'b01, d); check({tag, ".x"},      d, h[17:9]);
    peek(2'b10, d); check({tag, ".y"},      d, h[8:0]);
    peek(2'b11, d); check({tag, ".stat"},   d, {ovf_m, sb.size() == 0, 7'(sb.size())});
`ifdef MOUSE_FIFO_IRQ_EN
    check({tag, ".irq"}, {8'd0, irq}, {8'd0, irq_m});
`endif
  endtask

  // One clock with the given inputs; the model follows the same edge.
  task automatic do_cycle(input logic v, input logic [26:0] p, input logic rd, input logic [1:0] a);
    logic pop_m, set_m, stat_m, irq_nx;
    pop_m  = rd && (a == 2'b10) && (sb.size() != 0);
    set_m  = v && (sb.size() == DEPTH) && !pop_m;
    stat_m = rd && (a == 2'b11);
    irq_nx = (sb.size() != 0) || ovf_m;
    pkt_valid = v;
    {pkt_status, pkt_x, pkt_y} = p;
    io_cs = rd;
    io_rd = rd;
    addr  = a;
    @(posedge clk);
    #1;
    pkt_valid = 1'b0;
    io_cs = 1'b0;
    io_rd = 1'b0;
    if (pop_m) void'(sb.pop_front());
    if (v && !set_m) sb.push_back(p);
    ovf_m = set_m | (ovf_m & ~stat_m);
    irq_m = irq_nx;
  endtask

  initial begin
    // Activity while held in reset must be ignored.
    rst = 1'b0;
    pkt_valid = 1'b1;
    {pkt_status, pkt_x, pkt_y} = pk(9'h055, 9'd10, 9'd20);
    io_cs = 1'b1; io_rd = 1'b1; addr = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    pkt_valid = 1'b0; io_cs = 1'b0; io_rd = 1'b0;
    check_all("reset");

    rst = 1'b1;
    do_cycle(1'b1, pk(9'h008, 9'd204, 9'd153), 1'b0, 2'b00);
    do_cycle(1'b1, pk(9'h018, 9'd205, 9'd150), 1'b0, 2'b00);
    check_all("two_pushed");
    do_cycle(1'b0, '0, 1'b1, 2'b00);
    do_cycle(1'b0, '0, 1'b1, 2'b01);
    check_all("no_pop_on_st_x");
    do_cycle(1'b0, '0, 1'b1, 2'b10);
    check_all("pop1");
    do_cycle(1'b0, '0, 1'b1, 2'b10);
    check_all("pop2");
    do_cycle(1'b0, '0, 1'b1, 2'b10);
    check_all("pop_empty");

    for (int i = 1; i <= 9; i++)
      do_cycle(1'b1, pk(9'(i), 9'(100 + i), 9'(50 + 3 * i)), 1'b0, 2'b00);
    check_all("overflow");
    do_cycle(1'b0, '0, 1'b1, 2'b11);
    check_all("ovf_clear");

    do_cycle(1'b1, pk(9'h1ff, 9'd409, 9'd307), 1'b1, 2'b10);
    check_all("full_push_pop");
    do_cycle(1'b1, pk(9'h0aa, 9'd1, 9'd2), 1'b1, 2'b11);
    check_all("ovf_beats_clear");
    do_cycle(1'b0, '0, 1'b1, 2'b11);
    check_all("ovf_clear2");

    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(1'b0, '0, 1'b1, 2'b10);
      check_all($sformatf("drain%0d", i));
    end
    do_cycle(1'b0, '0, 1'b0, 2'b00);
    check_all("idle_empty");

    do_cycle(1'b1, pk(9'h003, 9'd7, 9'd9), 1'b1, 2'b10);
    check_all("empty_push_pop");
    do_cycle(1'b1, pk(9'h021, 9'd300, 9'd200), 1'b0, 2'b00);
    do_cycle(1'b1, pk(9'h011, 9'd0, 9'd1), 1'b1, 2'b10);
    check_all("mid_push_pop");
    for (int i = 0; i < 2; i++) begin
      do_cycle(1'b0, '0, 1'b1, 2'b10);
      check_all($sformatf("mid_drain%0d", i));
    end

    do_cycle(1'b1, pk(9'h009, 9'd50, 9'd60), 1'b0, 2'b00);
    do_cycle(1'b0, '0, 1'b0, 2'b00);
    check_all("pre_reset");
    pkt_valid = 1'b1;
    {pkt_status, pkt_x, pkt_y} = pk(9'h0f0, 9'd11, 9'd12);
    #2;
    rst = 1'b0;
    sb.delete();
    ovf_m = 1'b0;
    irq_m = 1'b0;
    #1;
    pkt_valid = 1'b0;
    check_all("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    do_cycle(1'b1, pk(9'h001, 9'd2, 9'd3), 1'b0, 2'b00);
    check_all("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mouse_event_fifo.md
MOUSE_EVENT_FIFO -- requirements
Module: mouse_event_fifo

Interface
REQ-001 Parameter DEPTH, default 8, meaning packet-FIFO entries; SHALL be a power of two, 2..64.
REQ-002 clk  input  1  system clock; all state SHALL update on rising edge only.
REQ-003 rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 pkt_valid  input  1  one-cycle pulse from ps2_mouse dav: packet fields valid this cycle.
REQ-005 pkt_status  input  9  button/sign/overflow byte, zero-extended.
REQ-006 pkt_x  input  9  clamped cursor X, 0..409.
REQ-007 pkt_y  input  9  clamped cursor Y, 0..307.
REQ-008 io_cs  input  1  CPU I/O select.
REQ-009 io_rd  input  1  CPU read strobe, qualified by io_cs.
REQ-010 addr  input  2  register select.
REQ-011 data  output  9  read data, combinational from addr and registered state.
REQ-012 irq  output  1  present only with MOUSE_FIFO_IRQ_EN (REQ-032).

Function
REQ-013 Entry = {status[8:0], x[8:0], y[8:0]}, 27 bits; push SHALL occur on the clock edge ending a pkt_valid cycle.
REQ-014 Read map SHALL be: 00 head status, 01 head x, 10 head y, 11 {overflow, empty, count[6:0]}.
REQ-015 Head fields SHALL read 9'd0 when empty.
REQ-016 count SHALL be 0..DEPTH, zero-extended into 7 bits; empty = (count==0).
REQ-017 Pop SHALL occur on the edge ending a cycle with io_cs && io_rd && addr==2'b10 && !empty; reads of 00/01 SHALL NOT pop.
REQ-018 Read latency: data SHALL reflect the new head one cycle after a pop.
REQ-019 Push when count==DEPTH without a same-cycle pop SHALL drop the incoming packet, keep contents unchanged, and set sticky overflow.
REQ-020 Simultaneous push and pop with count==DEPTH SHALL pop the head and store the new packet; count unchanged; overflow not set.
REQ-021 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and preserve order.
REQ-022 Push with empty and a pop-qualified read SHALL store the packet; the pop SHALL be ignored (count becomes 1).
REQ-023 Read of addr 11 with io_cs && io_rd SHALL clear overflow on that edge; a same-edge overflow event SHALL win (flag stays 1).
REQ-024 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH without any extra cycle.
REQ-025 Ordering SHALL be strict FIFO; no packet reordering or duplication.

Reset
REQ-026 Reset assertion SHALL immediately clear count, pointers, overflow and irq; data SHALL read 0 at all addresses except 11 (= 9'h080, empty bit set).
REQ-027 Storage contents need not be cleared.
REQ-028 pkt_valid or a CPU read during reset SHALL have no effect; reset mid-packet or mid-pop SHALL discard that operation.
REQ-029 First push SHALL be accepted on the first rising edge after reset deassertion.

Configuration
REQ-030 Macro MOUSE_FIFO_IRQ_EN selects the interrupt feature.
REQ-031 Without it: no irq port; behaviour exactly REQ-013..REQ-029.
REQ-032 With it: irq SHALL be registered, rise one cycle after count becomes non-zero or overflow sets, stay high until count==0 and overflow==0, and reset to 0.

Structure
REQ-033 Shared package ps2_pkg SHALL hold the address constants (STATUS, POS_X, POS_Y, FIFO_STAT), entry field widths (9) and the packet entry typedef.
REQ-034 Storage SHALL be one sub-module mouse_fifo_mem (DEPTH x 27, one write port, one asynchronous read port); pointers, count and flags stay in the top.

Verification
REQ-035 Reset, then read all four addresses -> 0, 0, 0, 9'h080.
REQ-036 Push (9'h008, 204, 153), then (9'h018, 205, 150) -> addr 00/01/10 read 8/204/153; pop; next cycle read 24/205/150; count 0 after second pop.
REQ-037 Push 9 packets with DEPTH=8, no reads -> count 8, overflow 1, head is packet 1, packet 9 absent; read addr 11 clears overflow.
REQ-038 Full FIFO, push and pop on same edge -> count stays 8, overflow 0, new packet at tail.
REQ-039 Empty FIFO, pkt_valid with pop-qualified read same cycle -> count 1, head equals pushed packet.
REQ-040 With MOUSE_FIFO_IRQ_EN: single push -> irq high next cycle; pop to empty -> irq low next cycle; reset mid-stream -> irq 0 at once.
